// File: rtl/trap_span_walker_if.sv
// trap_span_walker_if: span output handshake between the walker and the span filler.
//   span_valid/span_ready : valid/ready transfer handshake
//   span_y/xl/xr          : span row and inclusive x bounds
interface trap_span_walker_if;
  logic       span_valid;
  logic       span_ready;
  logic [7:0] span_y;
  logic [7:0] span_xl;
  logic [7:0] span_xr;
  modport master (output span_valid, span_y, span_xl, span_xr, input span_ready);
  modport slave  (input span_valid, span_y, span_xl, span_xr, output span_ready);
endinterface

// File: rtl/trap_span_walker.sv
// trap_span_walker: latches a trapezoid descriptor and emits one clamped span per row.
//   clk, rst_n (async active-low); start + descriptor (y_top, height, xl_top, xr_top, slope_l, slope_r)
//   mul_a/mul_b/mul_p : time-shared external signed multiplier (slope x row)
//   span              : span handshake (master side)
//   busy, done        : walk in progress / one-cycle completion pulse
module trap_span_walker #(
  parameter int FRAC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  y_top,
  input  logic [7:0]  height,
  input  logic [7:0]  xl_top,
  input  logic [7:0]  xr_top,
  input  logic [8:0]  slope_l,
  input  logic [8:0]  slope_r,
  output logic [8:0]  mul_a,
  output logic [8:0]  mul_b,
  input  logic [17:0] mul_p,
  output logic        busy,
  output logic        done,
  trap_span_walker_if.master span
);
  typedef enum logic [2:0] {IDLE, MUL_L, MUL_R, EMIT, DONE} state_t;
  state_t state, state_d;
  logic [7:0] y_q, h_q, xl_top_q, xr_top_q, r, xl_n, xr_n, y_span, x_c;
  logic [8:0] sl_q, sr_q;
  logic signed [17:0] sum;
  logic valid_q, last, skip, advance;
  // Both edges share one adder and clamp; MUL_R selects the right-edge base.
  always_comb begin
    sum = $signed({10'd0, state == MUL_R ? xr_top_q : xl_top_q}) + ($signed(mul_p) >>> FRAC);
    x_c = sum < 0 ? 8'd0 : sum > 18'sd255 ? 8'd255 : sum[7:0];
    last = r == h_q - 8'd1;
    skip = state == MUL_R && xl_n > x_c;
    advance = skip || (state == EMIT && span.span_ready);
    mul_a = state == MUL_L ? sl_q : state == MUL_R ? sr_q : 9'd0;
    mul_b = state == MUL_L || state == MUL_R ? {1'b0, r} : 9'd0;
    state_d = state;
    case (state)
      IDLE:  state_d = start ? (height == 8'd0 ? DONE : MUL_L) : IDLE;
      MUL_L: state_d = MUL_R;
      MUL_R: state_d = skip ? (last ? DONE : MUL_L) : EMIT;
      EMIT:  state_d = span.span_ready ? (last ? DONE : MUL_L) : EMIT;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r <= '0;
      y_q <= '0;
      h_q <= '0;
      xl_top_q <= '0;
      xr_top_q <= '0;
      sl_q <= '0;
      sr_q <= '0;
      xl_n <= '0;
      xr_n <= '0;
      y_span <= '0;
      valid_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      valid_q <= state_d == EMIT;
      busy <= state_d != IDLE;
      done <= state_d == DONE;
      if (state == IDLE && start) begin
        y_q <= y_top;
        h_q <= height;
        xl_top_q <= xl_top;
        xr_top_q <= xr_top;
        // The multiplier cannot negate -256, so it is pulled in to -255.
        sl_q <= slope_l == 9'h100 ? 9'h101 : slope_l;
        sr_q <= slope_r == 9'h100 ? 9'h101 : slope_r;
        r <= '0;
      end
      if (state == MUL_L) xl_n <= x_c;
      if (state == MUL_R) begin
        xr_n <= x_c;
        y_span <= y_q + r;
      end
      if (advance && !last) r <= r + 8'd1;
    end
  end
  assign span.span_valid = valid_q;
  assign span.span_y = y_span;
  assign span.span_xl = xl_n;
  assign span.span_xr = xr_n;
endmodule
